fp_add_arbiter: RTL and testbench
=================================

// Module: fp_add_arbiter
// PURPOSE
//   Shares one pipelined adder_32bit between NUM_REQ requesters (e.g. matrix-multiplier
//   accumulators) using round-robin arbitration. Grants at most one operand pair per cycle.
//   Tags each issued operation in an in-order tag FIFO and routes each adder result back
//   to the requester that issued it. Sits between the accumulators and the shared adder.
// PARAMETERS
//   NUM_REQ       4   number of requesters, 2..8
//   MAX_INFLIGHT  8   max outstanding adder ops = tag FIFO depth; power of two, >= adder latency
// PORTS
//   clk        in   1          clock; all logic on rising edge
//   rst        in   1          synchronous, active-high reset
//   req_vld    in   NUM_REQ    per-requester operand valid
//   req_a      in   32*NUM_REQ operand A; requester i at bits [32*i+31:32*i], IEEE-754 single
//   req_b      in   32*NUM_REQ operand B; same packing
//   req_rdy    out  NUM_REQ    one-hot grant; handshake = req_vld[i] & req_rdy[i]
//   add_a      out  32         operand A to adder i_a
//   add_b      out  32         operand B to adder i_b
//   add_vld    out  1          to adder i_vld
//   add_res    in   32         from adder o_res
//   add_res_vld in  1          from adder o_res_vld
//   add_ovf    in   1          from adder overflow
//   rsp_vld    out  NUM_REQ    one-hot result valid, 1-cycle pulse; no backpressure
//   rsp_res    out  32         result (valid while any rsp_vld bit is set)
//   rsp_ovf    out  1          overflow flag for rsp_res
//   busy       out  1          1 while tag FIFO count != 0
//   err        out  1          sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: all outputs 0; rr pointer = NUM_REQ-1 (requester 0 wins first); tag FIFO empty, count 0.
//   - Grant (combinational): if count < MAX_INFLIGHT, req_rdy = one-hot of the first set req_vld bit
//     searching ptr+1, ptr+2, ... modulo NUM_REQ. Otherwise req_rdy = 0.
//   - Full FIFO: no grant, even if a result pops in the same cycle (no bypass).
//   - Requester holds req_a/req_b stable while req_vld is high until handshake; requester may not
//     drop req_vld before handshake.
//   - On handshake in cycle T: ptr <= granted index; add_a/add_b/add_vld registered, so add_vld=1
//     in cycle T+1 only (add_vld=0 in any cycle without a grant); granted index pushed to tag FIFO.
//   - On add_res_vld in cycle R: pop FIFO head id; in R+1, rsp_vld[id]=1, rsp_res=add_res,
//     rsp_ovf=add_ovf. Results return in issue order (adder has fixed latency, in-order).
//   - Simultaneous push and pop: count unchanged, both take effect.
//   - add_res_vld with empty FIFO: result dropped, rsp_vld stays 0, count stays 0.
//   - Round-robin fairness: a continuously requesting input is granted within NUM_REQ grants.
//   - Reset mid-operation: FIFO cleared, pending responses discarded. The adder shares rst, so no
//     stale results return after reset.
//   - Throughput: 1 op/cycle sustained while count < MAX_INFLIGHT.
// CONFIGURATION
//   FP_ARB_ERR_CHECK_EN defined:
//     - err <= 1 (sticky until rst) on add_res_vld with empty FIFO.
//     - err <= 1 on any cycle where req_vld[i] falls without a handshake.
//   FP_ARB_ERR_CHECK_EN undefined: checker logic absent; err tied to 0; all other behaviour identical.
// TESTING
//   1) Reset; req0 = 0x40600000 + 0xC0100000 -> add_vld 1 cycle after grant;
//      rsp_vld=4'b0001, rsp_res=0x3FA00000 (1.25).
//   2) All four requesters valid every cycle -> grants 0,1,2,3,0,... with one add_vld per cycle;
//      each result (0x3F800000+0x40000000 -> 0x40400000) returns to the issuing requester.
//   3) Adder stalled from returning (model) with MAX_INFLIGHT=8 -> 8 grants, then req_rdy=0;
//      one add_res_vld -> exactly one further grant, the cycle after the pop.
//   4) Push+pop in the same cycle with count=3 -> count stays 3; busy stays 1; ids remain in order.
//   5) +Inf (0x7F800000) + +Inf from req2 -> rsp_vld=4'b0100, rsp_res=0x7F800000,
//      rsp_ovf mirrors adder overflow.
//   6) Assert rst with 3 ops in flight -> next cycle busy=0, no rsp_vld; with FP_ARB_ERR_CHECK_EN,
//      a stray add_res_vld sets err=1, which holds until rst.

Source files
------------

// File: rtl/fp_add_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : fp_add_arbiter
// Description : Round-robin arbiter sharing one pipelined single-precision
//               adder between NUM_REQ requesters. At most one operand pair is
//               issued per cycle. The requester id of every issued operation
//               is kept in an in-order tag FIFO, and each adder result is
//               routed back to the requester that issued it.
// Parameters  : NUM_REQ      - requesters (2..8)
//               MAX_INFLIGHT - outstanding adder ops / tag FIFO depth
//                              (power of two, >= adder latency)
// Ports       : clk, rst        - clock, synchronous active-high reset
//               req_vld/a/b     - per-requester operand valid and operands
//               req_rdy         - one-hot grant
//               add_a/b/vld     - registered operands to the shared adder
//               add_res/vld/ovf - adder result, valid and overflow
//               rsp_vld/res/ovf - one-hot result pulse, result, overflow
//               busy            - operations outstanding
//               err             - sticky protocol error
// Options     : FP_ARB_ERR_CHECK_EN - when defined, enables the protocol
//               checker driving err; otherwise err is tied to 0.
// Revision    : 1.0 - initial release
//==============================================================================
module fp_add_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_vld,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_rdy,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  output logic                   add_vld,
  input  logic [31:0]            add_res,
  input  logic                   add_res_vld,
  input  logic                   add_ovf,
  output logic [NUM_REQ-1:0]     rsp_vld,
  output logic [31:0]            rsp_res,
  output logic                   rsp_ovf,
  output logic                   busy,
  output logic                   err
);

  localparam int c_idx_w = $clog2(NUM_REQ);
  localparam int c_aw    = $clog2(MAX_INFLIGHT);
  localparam int c_cnt_w = c_aw + 1;
  localparam logic [c_cnt_w-1:0] c_max = c_cnt_w'(MAX_INFLIGHT);

  logic [c_idx_w-1:0] r_ptr;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_aw-1:0]    r_wr;
  logic [c_aw-1:0]    r_rd;
  logic [c_idx_w-1:0] r_tag [MAX_INFLIGHT];
  logic [31:0]        r_add_a;
  logic [31:0]        r_add_b;
  logic               r_add_vld;
  logic [NUM_REQ-1:0] r_rsp_vld;
  logic [31:0]        r_rsp_res;
  logic               r_rsp_ovf;

  logic [NUM_REQ-1:0] w_grant;
  logic [c_idx_w-1:0] w_gidx;
  logic [c_idx_w-1:0] w_cand;
  logic               w_found;
  logic               w_push;
  logic               w_pop;
  logic [NUM_REQ-1:0] w_head_oh;

  // Search starts just after the last winner; a full FIFO blocks the grant
  // regardless of a same-cycle pop, so the count test uses the registered value.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_cand  = '0;
    w_found = 1'b0;
    if (r_cnt < c_max) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        w_cand = c_idx_w'((int'(r_ptr) + k) % NUM_REQ);
        if (!w_found && req_vld[w_cand]) begin
          w_found         = 1'b1;
          w_gidx          = w_cand;
          w_grant[w_cand] = 1'b1;
        end
      end
    end
  end

  // A grant is only ever raised on a valid requester, so it is the handshake.
  assign w_push    = w_found;
  // Results arriving with nothing outstanding are dropped.
  assign w_pop     = add_res_vld && (r_cnt != '0);
  assign w_head_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_tag[r_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= c_idx_w'(NUM_REQ - 1);
      r_cnt     <= '0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_vld <= 1'b0;
      r_rsp_vld <= '0;
      r_rsp_res <= '0;
      r_rsp_ovf <= 1'b0;
    end else begin
      r_add_vld <= w_push;
      if (w_push) begin
        r_ptr   <= w_gidx;
        r_add_a <= req_a[32*w_gidx +: 32];
        r_add_b <= req_b[32*w_gidx +: 32];
        r_wr    <= r_wr + c_aw'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + c_aw'(1);
      end
      r_rsp_vld <= w_pop ? w_head_oh : '0;
      r_rsp_res <= w_pop ? add_res : '0;
      r_rsp_ovf <= w_pop & add_ovf;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + c_cnt_w'(1);
        2'b01:   r_cnt <= r_cnt - c_cnt_w'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag[r_wr] <= w_gidx;
    end
  end

`ifdef FP_ARB_ERR_CHECK_EN
  // Requesters still waiting at the end of the previous cycle; any of them
  // dropping valid now withdrew a request without a handshake.
  logic [NUM_REQ-1:0] r_req_pend;
  logic               r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_pend <= '0;
      r_err      <= 1'b0;
    end else begin
      r_req_pend <= req_vld & ~w_grant;
      if ((add_res_vld && (r_cnt == '0)) || (|(r_req_pend & ~req_vld))) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign req_rdy = w_grant;
  assign add_a   = r_add_a;
  assign add_b   = r_add_b;
  assign add_vld = r_add_vld;
  assign rsp_vld = r_rsp_vld;
  assign rsp_res = r_rsp_res;
  assign rsp_ovf = r_rsp_ovf;
  assign busy    = (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_fp_add_arbiter
// Description : Self-checking bench for fp_add_arbiter with a fixed-latency
//               adder model that can be overridden by hand-driven results.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_fp_add_arbiter;

  localparam int N   = 4;
  localparam int LAT = 3;
`ifdef FP_ARB_ERR_CHECK_EN
  localparam logic c_err = 1'b1;
`else
  localparam logic c_err = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    req_rdy;
  logic [31:0]     add_a;
  logic [31:0]     add_b;
  logic            add_vld;
  logic [31:0]     add_res;
  logic            add_res_vld;
  logic            add_ovf;
  logic [N-1:0]    rsp_vld;
  logic [31:0]     rsp_res;
  logic            rsp_ovf;
  logic            busy;
  logic            err;

  always #5 clk = ~clk;

  fp_add_arbiter #(.NUM_REQ(N), .MAX_INFLIGHT(8)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_a(req_a), .req_b(req_b),
    .req_rdy(req_rdy), .add_a(add_a), .add_b(add_b), .add_vld(add_vld),
    .add_res(add_res), .add_res_vld(add_res_vld), .add_ovf(add_ovf),
    .rsp_vld(rsp_vld), .rsp_res(rsp_res), .rsp_ovf(rsp_ovf),
    .busy(busy), .err(err)
  );

  // Adder model: fixed latency, results from a table of known sums.
  logic        auto_mode;
  logic        man_vld;
  logic [31:0] man_res;
  logic        man_ovf;
  logic        m_vld [LAT];
  logic [31:0] m_a   [LAT];
  logic [31:0] m_b   [LAT];
  logic [32:0] m_out;

  function automatic logic [32:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40600000 && b == 32'hC0100000) return {1'b0, 32'h3FA00000};
    if (a == 32'h3F800000 && b == 32'h40000000) return {1'b0, 32'h40400000};
    if (a == 32'h7F800000 && b == 32'h7F800000) return {1'b1, 32'h7F800000};
    return {1'b0, a ^ b};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) m_vld[i] <= 1'b0;
    end else begin
      m_vld[0] <= add_vld;
      m_a[0]   <= add_a;
      m_b[0]   <= add_b;
      for (int i = 1; i < LAT; i++) begin
        m_vld[i] <= m_vld[i-1];
        m_a[i]   <= m_a[i-1];
        m_b[i]   <= m_b[i-1];
      end
    end
  end

  assign m_out       = fadd(m_a[LAT-1], m_b[LAT-1]);
  assign add_res     = auto_mode ? m_out[31:0]  : man_res;
  assign add_ovf     = auto_mode ? m_out[32]    : man_ovf;
  assign add_res_vld = auto_mode ? m_vld[LAT-1] : man_vld;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_vld;
    logic [31:0] exp_res;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [4];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step;
      if (rsp_vld != '0) begin
        ok = 1'b1;
        return;
      end
    end
    n_cmp++;
    n_fail++;
    $display("FAIL rsp_timeout: no rsp_vld within 20 cycles, expected one");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0]  q_vld [$];
    logic [31:0] q_res [$];
    logic [3:0]  pp_exp [3];
    logic        pp_busy [3];
    logic [3:0]  seen;
    bit          ok;

    vecs[0] = '{0, 32'h40600000, 32'hC0100000, 4'b0001, 32'h3FA00000, 1'b0};
    vecs[1] = '{2, 32'h7F800000, 32'h7F800000, 4'b0100, 32'h7F800000, 1'b1};
    vecs[2] = '{1, 32'h3F800000, 32'h40000000, 4'b0010, 32'h40400000, 1'b0};
    vecs[3] = '{3, 32'h3F800000, 32'h40000000, 4'b1000, 32'h40400000, 1'b0};
    pp_exp  = '{4'b0001, 4'b0001, 4'b0010};
    pp_busy = '{1'b1, 1'b1, 1'b0};

    rst = 1'b1; req_vld = '0; req_a = '0; req_b = '0;
    auto_mode = 1'b1; man_vld = 1'b0; man_res = '0; man_ovf = 1'b0;
    step; step;
    chk("rst_req_rdy", 32'(req_rdy), 32'h0);
    chk("rst_add_vld", 32'(add_vld), 32'h0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'h0);
    chk("rst_rsp_res", rsp_res, 32'h0);
    chk("rst_rsp_ovf", 32'(rsp_ovf), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    step;

    // Single operations, one per vector.
    for (int i = 0; i < 4; i++) begin
      req_a[32*vecs[i].id +: 32] = vecs[i].a;
      req_b[32*vecs[i].id +: 32] = vecs[i].b;
      req_vld = '0;
      req_vld[vecs[i].id] = 1'b1;
      #1;
      chk("vec_grant", 32'(req_rdy), 32'(vecs[i].exp_vld));
      step;
      req_vld = '0;
      chk("vec_add_vld", 32'(add_vld), 32'h1);
      chk("vec_add_a", add_a, vecs[i].a);
      chk("vec_add_b", add_b, vecs[i].b);
      chk("vec_busy", 32'(busy), 32'h1);
      wait_rsp(ok);
      if (ok) begin
        chk("vec_rsp_vld", 32'(rsp_vld), 32'(vecs[i].exp_vld));
        chk("vec_rsp_res", rsp_res, vecs[i].exp_res);
        chk("vec_rsp_ovf", 32'(rsp_ovf), 32'(vecs[i].exp_ovf));
      end
      step;
      chk("vec_rsp_pulse", 32'(rsp_vld), 32'h0);
      chk("vec_idle", 32'(busy), 32'h0);
    end

    // All four requesting: grants rotate 0,1,2,3; each drops after its 3rd grant.
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = 32'h3F800000;
      req_b[32*i +: 32] = 32'h40000000;
    end
    req_vld = 4'hF;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("rr_grant", 32'(req_rdy), 32'h1 << (k % 4));
      step;
      chk("rr_add_vld", 32'(add_vld), 32'h1);
      if (rsp_vld != '0) begin q_vld.push_back(rsp_vld); q_res.push_back(rsp_res); end
      if (k >= 8) req_vld[k % 4] = 1'b0;
    end
    for (int c = 0; c < 10; c++) begin
      step;
      if (rsp_vld != '0) begin q_vld.push_back(rsp_vld); q_res.push_back(rsp_res); end
    end
    chk("rr_add_idle", 32'(add_vld), 32'h0);
    chk("rr_rsp_count", 32'(q_vld.size()), 32'd12);
    for (int j = 0; j < q_vld.size(); j++) begin
      chk("rr_rsp_vld", 32'(q_vld[j]), 32'h1 << (j % 4));
      chk("rr_rsp_res", q_res[j], 32'h40400000);
    end

    // Adder held off: fill all 8 slots from requester 0.
    auto_mode = 1'b0;
    req_vld = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("full_grant", 32'(req_rdy), 32'h1);
      step;
    end
    #1;
    chk("full_no_grant", 32'(req_rdy), 32'h0);
    chk("full_busy", 32'(busy), 32'h1);
    step;
    chk("full_hold", 32'(req_rdy), 32'h0);
    man_res = 32'h11111111;
    man_vld = 1'b1;
    #1;
    chk("full_no_bypass", 32'(req_rdy), 32'h0);
    step;
    man_vld = 1'b0;
    chk("pop_rsp_vld", 32'(rsp_vld), 32'h1);
    chk("pop_rsp_res", rsp_res, 32'h11111111);
    chk("pop_regrant", 32'(req_rdy), 32'h1);
    step;
    chk("pop_add_vld", 32'(add_vld), 32'h1);
    chk("pop_refull", 32'(req_rdy), 32'h0);
    req_vld = '0;
    step;
    chk("pop_add_idle", 32'(add_vld), 32'h0);
    // Drain to three outstanding.
    for (int p = 0; p < 5; p++) begin
      man_res = 32'h100 + 32'(p);
      man_vld = 1'b1;
      step;
      man_vld = 1'b0;
      chk("drain_rsp_vld", 32'(rsp_vld), 32'h1);
      chk("drain_rsp_res", rsp_res, 32'h100 + 32'(p));
    end

    // Push and pop together with three outstanding.
    req_a[63:32] = 32'h3F800000;
    req_b[63:32] = 32'h40000000;
    req_vld = 4'b0010;
    man_res = 32'h200;
    man_vld = 1'b1;
    #1;
    chk("pp_grant", 32'(req_rdy), 32'h2);
    step;
    req_vld = '0;
    man_vld = 1'b0;
    chk("pp_rsp_vld", 32'(rsp_vld), 32'h1);
    chk("pp_add_vld", 32'(add_vld), 32'h1);
    chk("pp_busy", 32'(busy), 32'h1);
    for (int p = 0; p < 3; p++) begin
      man_vld = 1'b1;
      step;
      man_vld = 1'b0;
      chk("pp_order", 32'(rsp_vld), 32'(pp_exp[p]));
      chk("pp_count", 32'(busy), 32'(pp_busy[p]));
    end

    // Result with nothing outstanding.
    man_vld = 1'b1;
    step;
    man_vld = 1'b0;
    chk("empty_pop_rsp", 32'(rsp_vld), 32'h0);
    chk("empty_pop_busy", 32'(busy), 32'h0);
    chk("empty_pop_err", 32'(err), 32'(c_err));

    // Reset with three in flight.
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rst2_err", 32'(err), 32'h0);
    auto_mode = 1'b1;
    req_a[31:0] = 32'h3F800000;
    req_b[31:0] = 32'h40000000;
    req_vld = 4'b0001;
    step; step; step;
    req_vld = '0;
    chk("mid_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_rsp_vld", 32'(rsp_vld), 32'h0);
    chk("mid_add_vld", 32'(add_vld), 32'h0);
    seen = '0;
    for (int c = 0; c < 8; c++) begin
      step;
      seen = seen | rsp_vld;
    end
    chk("mid_no_stale", 32'(seen), 32'h0);
    auto_mode = 1'b0;
    man_vld = 1'b1;
    step;
    man_vld = 1'b0;
    chk("stray_rsp", 32'(rsp_vld), 32'h0);
    chk("stray_err", 32'(err), 32'(c_err));
    step; step;
    chk("stray_err_hold", 32'(err), 32'(c_err));
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("err_cleared", 32'(err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
